// File: rtl/pim_weight_loader.sv
// Streams DEPTH kernels into consecutive PIM rows, one row write per accepted kernel.
// Optional PIM_WLOAD_CHECKSUM_EN adds a 16-bit running sum of every accepted weight.
module pim_weight_loader #(
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 1,
  parameter int DEPTH       = 6,
  parameter int BIT_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 4,
  localparam int W = KERNEL_SIZE * KERNEL_SIZE * CHANNEL * BIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  in_ready,
  output logic                  pim_weorca,
  output logic [ADDR_WIDTH-1:0] pim_addr,
  output logic [W-1:0]          pim_data,
  output logic                  busy,
  output logic                  done
`ifdef PIM_WLOAD_CHECKSUM_EN
  ,output logic [15:0]          checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;

  // Dropping start must block a handshake in the same cycle, so ready is gated by it.
  assign in_ready = (state == LOAD) && start;
  assign accept   = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      pim_addr   <= '0;
      pim_data   <= '0;
      pim_weorca <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pim_weorca <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (!start) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else if (in_valid) begin
            pim_data   <= in_data;
            pim_addr   <= idx;
            pim_weorca <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (!start) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else if (idx == LAST_ROW) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + ADDR_WIDTH'(1);
            state <= LOAD;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIM_WLOAD_CHECKSUM_EN
  localparam int NUM_WEIGHTS = KERNEL_SIZE * KERNEL_SIZE * CHANNEL;

  logic [15:0] kernel_sum;

  always_comb begin
    kernel_sum = '0;
    for (int i = 0; i < NUM_WEIGHTS; i++)
      kernel_sum = kernel_sum + 16'(in_data[i*BIT_WIDTH +: BIT_WIDTH]);
  end

  // Cleared while idle so each load starts from zero; wraps modulo 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      checksum <= '0;
    else if (state == IDLE)
      checksum <= '0;
    else if (accept)
      checksum <= checksum + kernel_sum;
  end
`endif

endmodule

// File: tb/tb_pim_weight_loader.sv
// Randomized self-checking bench for pim_weight_loader against a row-counting transaction model.
module tb_pim_weight_loader;
  localparam int KERNEL_SIZE = 5;
  localparam int CHANNEL     = 1;
  localparam int DEPTH       = 6;
  localparam int BIT_WIDTH   = 8;
  localparam int ADDR_WIDTH  = 4;
  localparam int W           = KERNEL_SIZE * KERNEL_SIZE * CHANNEL * BIT_WIDTH;
  localparam int NWEIGHTS    = KERNEL_SIZE * KERNEL_SIZE * CHANNEL;
  localparam int NW32        = (W + 31) / 32;
  localparam int VW          = 4 + ADDR_WIDTH + W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic                  pim_weorca;
  logic [ADDR_WIDTH-1:0] pim_addr;
  logic [W-1:0]          pim_data;
  logic                  busy;
  logic                  done;
`ifdef PIM_WLOAD_CHECKSUM_EN
  logic [15:0]           checksum;
`endif

  pim_weight_loader #(
    .KERNEL_SIZE(KERNEL_SIZE), .CHANNEL(CHANNEL), .DEPTH(DEPTH),
    .BIT_WIDTH(BIT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pim_weorca(pim_weorca), .pim_addr(pim_addr),
    .pim_data(pim_data), .busy(busy), .done(done)
`ifdef PIM_WLOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a load session counts accepted rows; each acceptance yields one write cycle.
  bit                    m_active;
  bit                    m_wr;
  bit                    m_done;
  int                    m_rows;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [W-1:0]          m_data;
  logic [15:0]           m_sum;

  function automatic logic [15:0] weight_sum(input logic [W-1:0] k);
    logic [15:0] s = '0;
    for (int i = 0; i < NWEIGHTS; i++) s = s + 16'(k[i*BIT_WIDTH +: BIT_WIDTH]);
    return s;
  endfunction

  function automatic logic [W-1:0] rand_kernel();
    logic [NW32*32-1:0] t;
    for (int i = 0; i < NW32; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [VW-1:0] expected_vec();
    return {m_active && !m_wr && start, m_wr, m_active, m_done, m_addr, m_data};
  endfunction

  function automatic logic [VW-1:0] observed_vec();
    return {in_ready, pim_weorca, busy, done, pim_addr, pim_data};
  endfunction

  task automatic model_reset();
    m_active = 0; m_wr = 0; m_done = 0; m_rows = 0;
    m_addr = '0; m_data = '0; m_sum = '0;
  endtask

  task automatic model_update();
    if (m_done) begin
      if (!start) m_done = 0;
    end else if (m_wr) begin
      m_wr = 0;
      if (!start) begin
        m_active = 0; m_rows = 0;
      end else if (m_rows == DEPTH) begin
        m_active = 0; m_done = 1;
      end
    end else if (m_active) begin
      if (!start) begin
        m_active = 0; m_rows = 0;
      end else if (in_valid) begin
        m_wr   = 1;
        m_addr = ADDR_WIDTH'(m_rows);
        m_data = in_data;
        m_rows++;
        m_sum  = m_sum + weight_sum(in_data);
      end
    end else begin
      m_sum = '0; m_rows = 0;
      if (start) m_active = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) tick();
    checks++;
    if (observed_vec() !== '0)
      begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", observed_vec()); end
    rst = 1'b1;
    tick();
    checks++;
    if (observed_vec() !== expected_vec())
      begin errors++; $display("[TB] FAIL reset_release: got %h expected %h", observed_vec(), expected_vec()); end
  endtask

  task automatic test_full_stream();
    int first_done = -1;
    start = 1'b1; in_valid = 1'b1; in_data = rand_kernel();
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL stream_c%0d: got %h expected %h", c, observed_vec(), expected_vec()); end
      if (done && first_done < 0) first_done = c;
      in_data = rand_kernel();
    end
    checks++;
    if (first_done != 13)
      begin errors++; $display("[TB] FAIL done_cycle: got %0d expected 13", first_done); end
    start = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL done_release: got %h expected %h", observed_vec(), expected_vec()); end
    end
  endtask

  task automatic test_stall();
    bit seen = 0;
    start = 1'b1; in_valid = 1'b1; in_data = rand_kernel();
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL stall_lead: got %h expected %h", observed_vec(), expected_vec()); end
      if (m_wr && m_addr == 1) seen = 1;
      in_data = rand_kernel();
    end
    if (!seen) begin errors++; $display("[TB] FAIL stall_row1_timeout: got none expected addr 1 write"); end
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || pim_weorca !== 1'b0 || pim_addr !== ADDR_WIDTH'(1))
        begin errors++; $display("[TB] FAIL stall_hold: got rdy=%b we=%b addr=%0d expected 1 0 1", in_ready, pim_weorca, pim_addr); end
    end
    in_valid = 1'b1;
    repeat (12) begin
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL stall_resume: got %h expected %h", observed_vec(), expected_vec()); end
      in_data = rand_kernel();
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort_write();
    bit seen = 0;
    start = 1'b1; in_valid = 1'b1; in_data = rand_kernel();
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL abort_lead: got %h expected %h", observed_vec(), expected_vec()); end
      if (m_wr && m_addr == 3) seen = 1;
      else in_data = rand_kernel();
    end
    if (!seen) begin errors++; $display("[TB] FAIL abort_row3_timeout: got none expected addr 3 write"); end
    checks++;
    if (pim_weorca !== 1'b1 || pim_addr !== ADDR_WIDTH'(3))
      begin errors++; $display("[TB] FAIL abort_pulse: got we=%b addr=%0d expected 1 3", pim_weorca, pim_addr); end
    start = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pim_weorca !== 1'b0 || observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL abort_idle: got %h expected %h", observed_vec(), expected_vec()); end
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; in_valid = 1'b0; in_data = rand_kernel();
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (observed_vec() !== '0)
      begin errors++; $display("[TB] FAIL async_reset: got %h expected 0", observed_vec()); end
    model_reset();
    in_valid = 1'b1;
    repeat (2) begin
      tick();
      checks++;
      if (observed_vec() !== '0)
        begin errors++; $display("[TB] FAIL reset_held: got %h expected 0", observed_vec()); end
    end
    rst = 1'b1; start = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (pim_weorca !== 1'b0 || observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL post_reset: got %h expected %h", observed_vec(), expected_vec()); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start    = ($urandom_range(0, 19) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand_kernel();
      tick();
      checks++;
      if (observed_vec() !== expected_vec())
        begin errors++; $display("[TB] FAIL random_c%0d: got %h expected %h", c, observed_vec(), expected_vec()); end
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

`ifdef PIM_WLOAD_CHECKSUM_EN
  task automatic test_checksum();
    bit seen = 0;
    for (int i = 0; i < NWEIGHTS; i++) in_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(1);
    start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (m_done) seen = 1;
    end
    checks++;
    if (!seen || done !== 1'b1 || checksum !== 16'd150 || checksum !== m_sum)
      begin errors++; $display("[TB] FAIL checksum: got done=%b sum=%0d expected 1 150", done, checksum); end
    start = 1'b0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_stream();
    test_stall();
    test_abort_write();
    test_reset_mid_load();
    test_random();
`ifdef PIM_WLOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pim_weight_loader.md
PIM_WEIGHT_LOADER -- requirements
Module: pim_weight_loader

Interface
REQ-001 Parameter KERNEL_SIZE, default 5, kernel edge length.
REQ-002 Parameter CHANNEL, default 1, input channels per kernel.
REQ-003 Parameter DEPTH, default 6, kernels (PIM rows) per load.
REQ-004 Parameter BIT_WIDTH, default 8, bits per weight.
REQ-005 Parameter ADDR_WIDTH, default 4, PIM row address width; 2**ADDR_WIDTH >= DEPTH.
REQ-006 Derived width W = KERNEL_SIZE*KERNEL_SIZE*CHANNEL*BIT_WIDTH; default 200.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  level enable; high runs a load, low aborts or idles.
REQ-010 in_valid  input  1  kernel word present on in_data.
REQ-011 in_data  input  W  one full kernel, weight 0 in LSBs.
REQ-012 in_ready  output  1  loader accepts in_data this cycle.
REQ-013 pim_weorca  output  1  PIM write strobe; 1 = write row, 0 = compute/read.
REQ-014 pim_addr  output  ADDR_WIDTH  PIM row being written.
REQ-015 pim_data  output  W  registered kernel data to PIM.
REQ-016 busy  output  1  high in LOAD or WRITE.
REQ-017 done  output  1  level; all DEPTH rows written.

Function
REQ-018 FSM states: IDLE, LOAD, WRITE, DONE; row counter idx, 0..DEPTH-1.
REQ-019 IDLE: in_ready=0, pim_weorca=0; start=1 -> LOAD, idx<=0.
REQ-020 LOAD: in_ready=1 (combinational from state, independent of in_valid); in_valid=1 -> capture in_data to pim_data, pim_addr<=idx, -> WRITE.
REQ-021 WRITE: pim_weorca=1 for exactly one cycle, in_ready=0; then idx==DEPTH-1 -> DONE, else idx<=idx+1, -> LOAD.
REQ-022 Latency: handshake at edge N -> pim_weorca high in cycle N+1 with stable pim_addr/pim_data.
REQ-023 Throughput: max one kernel per 2 cycles; full load min 1+2*DEPTH cycles from start.
REQ-024 pim_addr and pim_data hold last value outside WRITE; change only on an accepted handshake.
REQ-025 DONE: done=1, in_ready=0, pim_weorca=0; held until start=0 -> IDLE (done=0 next cycle).
REQ-026 start=0 in LOAD or WRITE: -> IDLE next edge; an asserted pim_weorca pulse is not truncated nor repeated; done stays 0; idx reset.
REQ-027 in_valid ignored outside LOAD; in_valid with start=0 in LOAD is not accepted (in_ready gated by start).
REQ-028 idx never exceeds DEPTH-1; no wrap; extra in_valid after last row ignored.

Reset
REQ-029 rst=0 asynchronously forces IDLE: idx=0, in_ready=0, pim_weorca=0, pim_addr=0, pim_data=0, busy=0, done=0.
REQ-030 Reset mid-load discards partial load; restart requires start=1 after rst release.

Configuration
REQ-031 Macro PIM_WLOAD_CHECKSUM_EN defined: extra output checksum [15:0] = modulo-2^16 sum of all BIT_WIDTH weights of accepted kernels, cleared in IDLE, valid when done=1.
REQ-032 Macro undefined: no checksum port or logic; all other behaviour identical.

Verification
REQ-033 Defaults, start=1, in_valid=1 constant -> weorca pulses at addr 0..5 every 2nd cycle, done=1 at cycle 13.
REQ-034 in_valid deasserted 3 cycles before row 2 -> in_ready holds high, weorca low, addr stays 1 until accepted.
REQ-035 start dropped during WRITE of row 3 -> single weorca pulse addr 3, then IDLE, done=0, busy=0.
REQ-036 rst=0 mid-LOAD between edges -> all outputs 0 immediately, no weorca afterwards.
REQ-037 With PIM_WLOAD_CHECKSUM_EN, all weights 8'h01 -> checksum=16'd150 when done=1.
